// File: rtl/mem_burst_pkg.sv
// Shared types and defaults for the burst master that drives the 16x8 single-port memory.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RSP   = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int LEN_W_DEF   = 4;
  localparam int TMO_CYC_DEF = 15;

  // The timeout counter only has to reach TMO_CYC-1.
  function automatic int tmo_width(input int cyc);
    return (cyc < 3) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/mem_burst_chk.sv
// Read-beat pattern checker: counts completed read beats whose data differs from seed+k.
module mem_burst_chk #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_vld,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] exp_data,
  output logic [7:0]        err_cnt
);

  // Saturating mismatch counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (beat_vld && (rdata != exp_data) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_burst_master.sv
// Burst command to single-beat memory transaction sequencer with read response stream.
// Optional read-pattern checker and chk_err_cnt port when MEM_BURST_CHK_EN is defined.
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              mem_valid,
  output logic              mem_wr_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
`ifdef MEM_BURST_CHK_EN
  output logic [7:0]        chk_err_cnt,
`endif
  output logic              busy,
  output logic              tmo_err
);

  localparam int TMO_W = tmo_width(TMO_CYC);

  state_t           state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] beat_r;
  logic [TMO_W-1:0] tmo_cnt_r;

  // Burst sequencer; mem_addr/mem_wdata double as the running address and seed+k pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      len_r     <= '0;
      beat_r    <= '0;
      tmo_cnt_r <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      mem_valid <= 1'b0;
      mem_wr_rd <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      tmo_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            state_r   <= ISSUE;
            len_r     <= cmd_len;
            beat_r    <= '0;
            tmo_cnt_r <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            mem_valid <= 1'b1;
            mem_wr_rd <= cmd_wr;
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_wdata;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_wr_rd) begin
              state_r <= GAP;
            end else begin
              state_r   <= RSP;
              rsp_valid <= 1'b1;
              rsp_data  <= mem_rdata;
              rsp_last  <= (beat_r == len_r);
            end
          end else if (tmo_cnt_r == TMO_W'(TMO_CYC - 1)) begin
            // Abort: drop the request and discard the remaining beats.
            state_r   <= IDLE;
            mem_valid <= 1'b0;
            tmo_err   <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state_r   <= GAP;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
          end
        end
        GAP: begin
          if (beat_r == len_r) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            state_r   <= ISSUE;
            beat_r    <= beat_r + LEN_W'(1);
            tmo_cnt_r <= '0;
            mem_valid <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= mem_wdata + DATA_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_valid <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_last  <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_BURST_CHK_EN
  logic rd_done_s;
  assign rd_done_s = (state_r == ISSUE) && mem_valid && mem_ready && !mem_wr_rd;

  mem_burst_chk #(.DATA_W(DATA_W)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .beat_vld (rd_done_s),
    .rdata    (mem_rdata),
    .exp_data (mem_wdata),
    .err_cnt  (chk_err_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a registered-ack memory model.
module tb_mem_burst_master;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [3:0] cmd_addr, cmd_len;
  logic [7:0] cmd_wdata;
  logic       mem_valid, mem_wr_rd, mem_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [7:0] rsp_data;
  logic       busy, tmo_err;
`ifdef MEM_BURST_CHK_EN
  logic [7:0] chk_err_cnt;
`endif

  mem_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last),
`ifdef MEM_BURST_CHK_EN
    .chk_err_cnt(chk_err_cnt),
`endif
    .busy(busy), .tmo_err(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack one cycle after a request, then drop; mem_en=0 stalls forever.
  logic       mem_en;
  logic [7:0] mem_model [16];
  assign mem_rdata = mem_model[mem_addr];

  always @(posedge clk) begin
    if (rst) mem_ready <= 1'b0;
    else     mem_ready <= mem_en && mem_valid && !mem_ready;
  end

  // Monitors log completed writes, accepted responses, request rises and timeout pulses.
  logic [11:0] wr_log  [256];
  logic [8:0]  rsp_log [256];
  int          wr_n = 0, rsp_n = 0, rise_cnt = 0, tmo_n = 0;
  logic        mv_d = 1'b0;

  always @(posedge clk) begin
    mv_d <= mem_valid;
    if (!rst) begin
      if (mem_valid && mem_ready && mem_wr_rd) begin
        mem_model[mem_addr] <= mem_wdata;
        wr_log[wr_n[7:0]]   <= {mem_addr, mem_wdata};
        wr_n                <= wr_n + 1;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_log[rsp_n[7:0]] <= {rsp_last, rsp_data};
        rsp_n               <= rsp_n + 1;
      end
      if (mem_valid && !mv_d) rise_cnt <= rise_cnt + 1;
      if (tmo_err)            tmo_n    <= tmo_n + 1;
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [26:0] out_view();
    return {cmd_ready, busy, mem_valid, mem_wr_rd, mem_addr, mem_wdata,
            rsp_valid, rsp_data, rsp_last, tmo_err};
  endfunction

  task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [3:0] l,
                          input logic [7:0] s);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l; cmd_wdata = s;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 4'h0; cmd_len = 4'h0; cmd_wdata = 8'h00;
    check("accept_busy", busy, 1);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 500) check("idle_bound", busy, 0);
  endtask

  typedef struct {
    logic            wr;
    logic [3:0]      addr;
    logic [3:0]      len;
    logic [7:0]      seed;
    logic [3:0][3:0] ea;
    logic [3:0][7:0] ed;
    int              cyc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int c, wb, rb, r0, t0, g, n;
    vecs[0] = '{1'b1, 4'h2, 4'd3, 8'h10, {4'h5, 4'h4, 4'h3, 4'h2}, {8'h13, 8'h12, 8'h11, 8'h10}, 12};
    vecs[1] = '{1'b0, 4'h2, 4'd3, 8'h10, {4'h5, 4'h4, 4'h3, 4'h2}, {8'h13, 8'h12, 8'h11, 8'h10}, 16};
    vecs[2] = '{1'b1, 4'hE, 4'd3, 8'hFE, {4'h1, 4'h0, 4'hF, 4'hE}, {8'h01, 8'h00, 8'hFF, 8'hFE}, 12};
    vecs[3] = '{1'b0, 4'hE, 4'd3, 8'hFE, {4'h1, 4'h0, 4'hF, 4'hE}, {8'h01, 8'h00, 8'hFF, 8'hFE}, 16};
    vecs[4] = '{1'b1, 4'h7, 4'd0, 8'h55, {4'h0, 4'h0, 4'h0, 4'h7}, {8'h00, 8'h00, 8'h00, 8'h55}, 3};
    vecs[5] = '{1'b0, 4'h7, 4'd0, 8'h55, {4'h0, 4'h0, 4'h0, 4'h7}, {8'h00, 8'h00, 8'h00, 8'h55}, 4};

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 4'h0; cmd_len = 4'h0;
    cmd_wdata = 8'h00; rsp_ready = 1'b1; mem_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_view(), {1'b1, 26'd0});
    rst = 1'b0;
    @(negedge clk);

    // Table-driven bursts: write log / response stream, request count and busy length.
    for (int i = 0; i < 6; i++) begin
      wb = wr_n; rb = rsp_n; r0 = rise_cnt; t0 = tmo_n;
      send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].seed);
      wait_idle(c);
      check($sformatf("v%0d_busy_cycles", i), c, vecs[i].cyc);
      check($sformatf("v%0d_mem_valid_pulses", i), rise_cnt - r0, vecs[i].len + 1);
      check($sformatf("v%0d_no_tmo", i), tmo_n - t0, 0);
      if (vecs[i].wr) begin
        check($sformatf("v%0d_wr_count", i), wr_n - wb, vecs[i].len + 1);
        for (int k = 0; k <= int'(vecs[i].len); k++)
          check($sformatf("v%0d_wr%0d", i, k), wr_log[(wb + k) % 256],
                {vecs[i].ea[k], vecs[i].ed[k]});
      end else begin
        check($sformatf("v%0d_rsp_count", i), rsp_n - rb, vecs[i].len + 1);
        for (int k = 0; k <= int'(vecs[i].len); k++)
          check($sformatf("v%0d_rsp%0d", i, k), rsp_log[(rb + k) % 256],
                {(k == int'(vecs[i].len)), vecs[i].ed[k]});
      end
    end

    // Backpressure: beat 1 held for 5 cycles, no new request meanwhile.
    rsp_ready = 1'b0; rb = rsp_n;
    send_cmd(1'b0, 4'h2, 4'd3, 8'h10);
    for (int k = 0; k < 4; k++) begin
      g = 0;
      while (!rsp_valid && g < 50) begin g++; @(negedge clk); end
      check("bp_rsp_valid", rsp_valid, 1);
      if (k == 1) begin
        for (int h = 0; h < 5; h++) begin
          check("bp_hold", {rsp_valid, rsp_data, mem_valid}, {1'b1, 8'h11, 1'b0});
          @(negedge clk);
        end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    wait_idle(c);
    rsp_ready = 1'b1;
    check("bp_rsp_count", rsp_n - rb, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("bp_rsp%0d", k), rsp_log[(rb + k) % 256], {(k == 3), 8'h10 + 8'(k)});

    // Timeout: memory never acks.
    mem_en = 1'b0; rb = rsp_n; t0 = tmo_n;
    send_cmd(1'b0, 4'h0, 4'd3, 8'h00);
    n = 0; g = 0;
    while (!tmo_err && g < 100) begin
      if (mem_valid) n++;
      g++;
      @(negedge clk);
    end
    check("tmo_pulse", tmo_err, 1);
    check("tmo_issue_cycles", n, 15);
    @(negedge clk);
    check("tmo_after", {tmo_err, busy, cmd_ready, mem_valid}, 4'b0010);
    check("tmo_single_pulse", tmo_n - t0, 1);
    check("tmo_no_rsp", rsp_n - rb, 0);
    mem_en = 1'b1;

    // Reset during beat 2 of 4, then a clean new burst.
    wb = wr_n; r0 = rise_cnt;
    send_cmd(1'b1, 4'h8, 4'd3, 8'h40);
    g = 0;
    while (!((rise_cnt - r0 == 2) && mem_valid) && g < 50) begin g++; @(negedge clk); end
    check("mid_reach_beat2", rise_cnt - r0, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", out_view(), {1'b1, 26'd0});
    rst = 1'b0;
    check("mid_wr_count", wr_n - wb, 1);
    check("mid_wr0", wr_log[wb % 256], {4'h8, 8'h40});
    @(negedge clk);
    wb = wr_n;
    send_cmd(1'b1, 4'h9, 4'd1, 8'h77);
    wait_idle(c);
    check("post_busy_cycles", c, 6);
    check("post_wr_count", wr_n - wb, 2);
    check("post_wr0", wr_log[wb % 256], {4'h9, 8'h77});
    check("post_wr1", wr_log[(wb + 1) % 256], {4'hA, 8'h78});

`ifdef MEM_BURST_CHK_EN
    check("chk_clean", chk_err_cnt, 0);
    send_cmd(1'b0, 4'h2, 4'd0, 8'h00);
    wait_idle(c);
    check("chk_one_err", chk_err_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
